// File: rtl/dmem_addr_gen_if.sv
// Bus between the DMem request arbiter and the strided address generator.
// DMEM_ADDR_GEN_WRAP_CHECK_EN adds the sticky O_Wrap_Err flag.
interface dmem_addr_gen_if #(
    parameter int ADDR_WIDTH   = 16,
    parameter int STRIDE_WIDTH = 16
);
    logic                    I_Req;
    logic [1:0]              I_GrantNo;
    logic [ADDR_WIDTH-1:0]   I_Length;
    logic [STRIDE_WIDTH-1:0] I_Stride;
    logic [ADDR_WIDTH-1:0]   I_Base_Addr;
    logic                    I_Stall;
    logic [ADDR_WIDTH-1:0]   O_Addr;
    logic                    O_Valid;
    logic                    O_Term1;
    logic                    O_Term2;
    logic                    O_Term3;
    logic                    O_Busy;
    logic [ADDR_WIDTH-1:0]   O_Remain;
`ifdef DMEM_ADDR_GEN_WRAP_CHECK_EN
    logic                    O_Wrap_Err;
`endif

    modport master (
        output I_Req, I_GrantNo, I_Length, I_Stride, I_Base_Addr, I_Stall,
        input  O_Addr, O_Valid, O_Term1, O_Term2, O_Term3, O_Busy, O_Remain
`ifdef DMEM_ADDR_GEN_WRAP_CHECK_EN
        , input O_Wrap_Err
`endif
    );

    modport slave (
        input  I_Req, I_GrantNo, I_Length, I_Stride, I_Base_Addr, I_Stall,
        output O_Addr, O_Valid, O_Term1, O_Term2, O_Term3, O_Busy, O_Remain
`ifdef DMEM_ADDR_GEN_WRAP_CHECK_EN
        , output O_Wrap_Err
`endif
    );
endinterface

// File: rtl/dmem_addr_gen.sv
// Strided DMem address generator: one address per unstalled cycle, Term pulse to the granted lane.
// Optional sticky wrap detection with DMEM_ADDR_GEN_WRAP_CHECK_EN.
module dmem_addr_gen #(
    parameter int ADDR_WIDTH   = 16,
    parameter int STRIDE_WIDTH = 16
) (
    input logic            clock,
    input logic            reset,
    dmem_addr_gen_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, WAIT} state_t;

    state_t                  state, state_nxt;
    logic [1:0]              lane;
    logic [ADDR_WIDTH-1:0]   addr, addr_nxt, remain;
    logic [STRIDE_WIDTH-1:0] stride;
    logic                    valid, term;

    // Request level carries no control meaning here.
    logic unused_req;
    assign unused_req = bus.I_Req;

`ifdef DMEM_ADDR_GEN_WRAP_CHECK_EN
    // Two spare bits above the wider operand catch both carry-out and borrow.
    localparam int EW = ((ADDR_WIDTH > STRIDE_WIDTH) ? ADDR_WIDTH : STRIDE_WIDTH) + 2;
    logic [EW-1:0] addr_ext, stride_ext, sum_ext;
    logic          wrap, wrap_err;
    assign addr_ext   = EW'(addr);
    assign stride_ext = EW'($signed(stride));
    assign sum_ext    = addr_ext + stride_ext;
    assign addr_nxt   = sum_ext[ADDR_WIDTH-1:0];
    assign wrap       = |sum_ext[EW-1:ADDR_WIDTH];
    assign bus.O_Wrap_Err = wrap_err;

    always_ff @(posedge clock) begin
        if (reset)
            wrap_err <= 1'b0;
        else if (valid && wrap)
            wrap_err <= 1'b1;
    end
`else
    assign addr_nxt = addr + ADDR_WIDTH'($signed(stride));
`endif

    always_comb begin
        state_nxt = state;
        valid     = 1'b0;
        term      = 1'b0;
        case (state)
            IDLE: if (bus.I_GrantNo != 2'd0) state_nxt = RUN;
            RUN: begin
                if (bus.I_GrantNo != lane) begin
                    state_nxt = IDLE;
                end else if (remain == '0) begin
                    term      = 1'b1;
                    state_nxt = WAIT;
                end else begin
                    valid = ~bus.I_Stall;
                    if (valid && remain == ADDR_WIDTH'(1)) begin
                        term      = 1'b1;
                        state_nxt = WAIT;
                    end
                end
            end
            // Hold here until the grant drops so a stale grant cannot relaunch.
            WAIT: if (bus.I_GrantNo == 2'd0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            lane   <= 2'd0;
            addr   <= '0;
            stride <= '0;
            remain <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && bus.I_GrantNo != 2'd0) begin
                lane   <= bus.I_GrantNo;
                addr   <= bus.I_Base_Addr;
                stride <= bus.I_Stride;
                remain <= bus.I_Length;
            end else if (valid) begin
                addr   <= addr_nxt;
                remain <= remain - ADDR_WIDTH'(1);
            end
        end
    end

    assign bus.O_Addr   = addr;
    assign bus.O_Remain = remain;
    assign bus.O_Valid  = valid;
    assign bus.O_Busy   = (state != IDLE);
    assign bus.O_Term1  = term && (lane == 2'd1);
    assign bus.O_Term2  = term && (lane == 2'd2);
    assign bus.O_Term3  = term && (lane == 2'd3);
endmodule

// File: tb/tb_dmem_addr_gen.sv
// Directed bench for dmem_addr_gen: launch, stall, zero length, negative stride, reset/abort, back-to-back.
module tb_dmem_addr_gen;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    dmem_addr_gen_if #(.ADDR_WIDTH(16), .STRIDE_WIDTH(16)) bus ();

    dmem_addr_gen #(.ADDR_WIDTH(16), .STRIDE_WIDTH(16)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic grant(input logic [1:0] ln, input logic [15:0] len,
                         input logic [15:0] str, input logic [15:0] base);
        bus.I_Req       = (ln != 2'd0);
        bus.I_GrantNo   = ln;
        bus.I_Length    = len;
        bus.I_Stride    = str;
        bus.I_Base_Addr = base;
    endtask

    task automatic chk_issue(input string tag, input logic [15:0] a, input logic [2:0] terms);
        #1;
        chk({tag, ".valid"}, 32'(bus.O_Valid), 32'd1);
        chk({tag, ".addr"},  32'(bus.O_Addr),  32'(a));
        chk({tag, ".term"},  32'({bus.O_Term3, bus.O_Term2, bus.O_Term1}), 32'(terms));
    endtask

    logic [15:0] exp1 [4] = '{16'h0010, 16'h0013, 16'h0016, 16'h0019};
    logic [15:0] exp4 [3] = '{16'h0002, 16'h0000, 16'hFFFE};

    initial begin
        grant(2'd0, 16'd0, 16'd0, 16'd0);
        bus.I_Stall = 1'b0;
        step(); step();
        chk("rst.addr",   32'(bus.O_Addr), 32'd0);
        chk("rst.remain", 32'(bus.O_Remain), 32'd0);
        chk("rst.flags",  32'({bus.O_Valid, bus.O_Busy, bus.O_Term1, bus.O_Term2, bus.O_Term3}), 32'd0);
        reset = 1'b0;

        // Lane 2, four elements, stride 3.
        grant(2'd2, 16'd4, 16'd3, 16'h0010);
        step();
        for (int i = 0; i < 4; i++) begin
            chk_issue($sformatf("t1.%0d", i), exp1[i], (i == 3) ? 3'b010 : 3'b000);
            step();
        end
        #1;
        chk("t1.wait.busy",  32'(bus.O_Busy), 32'd1);
        chk("t1.wait.valid", 32'(bus.O_Valid), 32'd0);
        chk("t1.wait.term",  32'({bus.O_Term3, bus.O_Term2, bus.O_Term1}), 32'd0);
        grant(2'd0, 16'd0, 16'd0, 16'd0);
        step();
        chk("t1.idle.busy", 32'(bus.O_Busy), 32'd0);

        // Lane 1, stall on the 2nd and 3rd cycles.
        grant(2'd1, 16'd3, 16'd1, 16'h0100);
        step();
        chk_issue("t2.0", 16'h0100, 3'b000);
        step();
        bus.I_Stall = 1'b1; #1;
        chk("t2.stall1.valid",  32'(bus.O_Valid), 32'd0);
        chk("t2.stall1.remain", 32'(bus.O_Remain), 32'd2);
        step(); #1;
        chk("t2.stall2.valid",  32'(bus.O_Valid), 32'd0);
        chk("t2.stall2.remain", 32'(bus.O_Remain), 32'd2);
        chk("t2.stall2.addr",   32'(bus.O_Addr), 32'h0101);
        step();
        bus.I_Stall = 1'b0;
        chk_issue("t2.1", 16'h0101, 3'b000);
        step();
        chk_issue("t2.2", 16'h0102, 3'b001);
        step();
        grant(2'd0, 16'd0, 16'd0, 16'd0);
        step();

        // Lane 3, zero-length descriptor; stall must not block the Term.
        grant(2'd3, 16'd0, 16'd5, 16'h0ABC);
        step();
        bus.I_Stall = 1'b1; #1;
        chk("t3.valid", 32'(bus.O_Valid), 32'd0);
        chk("t3.term",  32'({bus.O_Term3, bus.O_Term2, bus.O_Term1}), 32'b100);
        step(); #1;
        bus.I_Stall = 1'b0;
        chk("t3.wait.term", 32'({bus.O_Term3, bus.O_Term2, bus.O_Term1}), 32'd0);
        chk("t3.wait.busy", 32'(bus.O_Busy), 32'd1);
        grant(2'd0, 16'd0, 16'd0, 16'd0);
        step();
        chk("t3.idle.busy", 32'(bus.O_Busy), 32'd0);

`ifdef DMEM_ADDR_GEN_WRAP_CHECK_EN
        chk("t4.wrap.before", 32'(bus.O_Wrap_Err), 32'd0);
`endif
        // Negative stride across zero.
        grant(2'd1, 16'd3, 16'hFFFE, 16'h0002);
        step();
        for (int i = 0; i < 3; i++) begin
            chk_issue($sformatf("t4.%0d", i), exp4[i], (i == 2) ? 3'b001 : 3'b000);
            step();
        end
`ifdef DMEM_ADDR_GEN_WRAP_CHECK_EN
        #1;
        chk("t4.wrap.after", 32'(bus.O_Wrap_Err), 32'd1);
`endif
        grant(2'd0, 16'd0, 16'd0, 16'd0);
        step();

        // Reset after three of eight addresses.
        grant(2'd1, 16'd8, 16'd4, 16'h0200);
        step();
        for (int i = 0; i < 3; i++) begin
            chk_issue($sformatf("t5.%0d", i), 16'(16'h0200 + 4 * i), 3'b000);
            step();
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        grant(2'd0, 16'd0, 16'd0, 16'd0);
        #1;
        chk("t5.rst.addr",   32'(bus.O_Addr), 32'd0);
        chk("t5.rst.remain", 32'(bus.O_Remain), 32'd0);
        chk("t5.rst.flags",  32'({bus.O_Valid, bus.O_Busy, bus.O_Term1, bus.O_Term2, bus.O_Term3}), 32'd0);
        step();

        // Grant dropped mid-RUN: abort, no Term.
        grant(2'd1, 16'd8, 16'd1, 16'h0300);
        step();
        chk_issue("t5b.0", 16'h0300, 3'b000);
        step();
        chk_issue("t5b.1", 16'h0301, 3'b000);
        grant(2'd0, 16'd0, 16'd0, 16'd0);
        #1;
        chk("t5b.abort.valid", 32'(bus.O_Valid), 32'd0);
        chk("t5b.abort.term",  32'({bus.O_Term3, bus.O_Term2, bus.O_Term1}), 32'd0);
        step();
        chk("t5b.idle.busy", 32'(bus.O_Busy), 32'd0);

        // Back-to-back: lane 1 then lane 2.
        grant(2'd1, 16'd2, 16'd1, 16'h0040);
        step();
        chk_issue("t6.0", 16'h0040, 3'b000);
        step();
        chk_issue("t6.1", 16'h0041, 3'b001);
        step();
        grant(2'd0, 16'd0, 16'd0, 16'd0);
        #1;
        chk("t6.wait.valid", 32'(bus.O_Valid), 32'd0);
        step();
        grant(2'd2, 16'd1, 16'd1, 16'h0080);
        #1;
        chk("t6.idle.valid", 32'(bus.O_Valid), 32'd0);
        chk("t6.idle.busy",  32'(bus.O_Busy), 32'd0);
        step();
        chk_issue("t6.lane2", 16'h0080, 3'b010);
        step();
        grant(2'd0, 16'd0, 16'd0, 16'd0);
        step();
        chk("t6.end.busy", 32'(bus.O_Busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
